// File: rtl/alu_sequencer.sv
// Fetch/execute core: fetches 16-bit instructions, sequences a 4x8 register file through an external ALU.
// ALU op takes 4 cycles and other ops 3 (with 1-cycle imem), stalls in WAIT until imem_valid.
module alu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [3:0]      alu_opcode,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_out,
  input  logic [3:0]      alu_flag,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_PARK = 4'hF;

  state_t          state;
  logic [15:0]     ir;
  logic [7:0]      regs [4];
  logic            armed;

  logic [3:0]      op;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic [7:0]      imm;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic            take_br;

  assign op        = ir[15:12];
  assign rd        = ir[11:10];
  assign rs        = ir[9:8];
  assign imm       = ir[7:0];
  assign pc_inc    = pc + PC_W'(1);
  assign target    = PC_W'(imm);
  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  always_comb begin
    take_br = 1'b0;
    case (op)
      4'h8:    take_br = flags[1];
      4'h9:    take_br = flags[3];
      4'hA:    take_br = flags[2];
      default: take_br = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      flags      <= '0;
      ir         <= '0;
      imem_req   <= 1'b0;
      alu_opcode <= OP_PARK;
      alu_a      <= '0;
      alu_b      <= '0;
      halted     <= 1'b0;
      armed      <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      // start in the first cycle after reset release is not honoured
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start && armed) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          imem_req <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            ir    <= imem_data;
            state <= S_EXEC;
            // operands are captured here so EXEC and WB present a stable ALU input
            if (imem_data[15:12] <= 4'h6) begin
              alu_opcode <= imem_data[15:12];
              alu_a      <= regs[imem_data[11:10]];
              alu_b      <= regs[imem_data[9:8]];
            end
          end
        end
        S_EXEC: begin
          if (op <= 4'h6) begin
            state <= S_WB;
          end else if (op == 4'hF) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            case (op)
              4'h7: begin
                regs[rd] <= imm;
                pc       <= pc_inc;
              end
              4'h8, 4'h9, 4'hA: pc <= take_br ? target : pc_inc;
              4'hB:             pc <= target;
              default:          pc <= pc_inc;
            endcase
          end
        end
        S_WB: begin
          regs[rd]   <= alu_out;
          flags      <= alu_flag;
          pc         <= pc_inc;
          alu_opcode <= OP_PARK;
          state      <= S_FETCH;
          imem_req   <= 1'b1;
        end
        S_HALT: begin
          if (start) begin
            pc       <= RESET_PC;
            halted   <= 1'b0;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an instruction memory responder, a behavioural ALU and an ALU-transaction scoreboard.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag;
  logic [7:0]  pc;
  logic [3:0]  flags;
  logic        halted;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .pc(pc), .flags(flags), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_exp_t;

  alu_exp_t    sb[$];
  logic [15:0] imem [256];
  int          nvec = 0;
  int          nerr = 0;
  int          lat = 1;
  int          req_cnt = 0;
  bit          saw_wrap = 0;
  int          cyc;
  logic [7:0]  rv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: carry > negative(borrow) > zero
  always_comb begin
    logic [8:0] s;
    s        = '0;
    alu_out  = '0;
    alu_flag = 4'b0000;
    case (alu_opcode)
      4'h0: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out  = s[7:0];
        alu_flag = s[8] ? 4'b1000 : (s[7:0] == 8'h00 ? 4'b0010 : 4'b0000);
      end
      4'h1: begin
        alu_out  = alu_a - alu_b;
        alu_flag = (alu_a < alu_b) ? 4'b0100 : (alu_a == alu_b ? 4'b0010 : 4'b0000);
      end
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a | alu_b;
      4'h4: alu_out = alu_a ^ alu_b;
      4'h5: alu_out = alu_a << 1;
      4'h6: alu_out = alu_a >> 1;
      default: alu_out = '0;
    endcase
    if (alu_opcode >= 4'h2 && alu_opcode <= 4'h6)
      alu_flag = (alu_out == 8'h00) ? 4'b0010 : 4'b0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_exp_t e;
    e.op = op;
    e.a  = a;
    e.b  = b;
    sb.push_back(e);
  endtask

  task automatic rd_reg(input logic [1:0] i, output logic [7:0] v);
    dbg_sel = i;
    #1;
    v = dbg_data;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_halt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
  endtask

  // Instruction memory: answers each request lat cycles later with a one-cycle valid
  initial begin
    logic [7:0] a;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        a = imem_addr;
        repeat (lat) @(posedge clk);
        #1;
        imem_valid = 1'b1;
        imem_data  = imem[a];
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
      end
    end
  end

  // Monitor: request pulses, pc wrap, and each new ALU transaction against the scoreboard
  initial begin
    logic [3:0] prev_op;
    logic [7:0] prev_pc;
    alu_exp_t   e;
    prev_op = 4'hF;
    prev_pc = 8'h00;
    forever begin
      @(negedge clk);
      if (imem_req) req_cnt++;
      if (prev_pc == 8'hFF && pc == 8'h00) saw_wrap = 1'b1;
      prev_pc = pc;
      if (alu_opcode != 4'hF && prev_op == 4'hF) begin
        if (sb.size() == 0) begin
          chk("alu_unexpected_op", alu_opcode, 4'hF);
        end else begin
          e = sb.pop_front();
          chk("alu_opcode", alu_opcode, e.op);
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
        end
      end
      prev_op = alu_opcode;
    end
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    dbg_sel = 2'd0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;

    // Reset state, and a start coincident with reset release is ignored
    repeat (3) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_alu_opcode", alu_opcode, 4'hF);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_start_ignored_req", req_cnt, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_flags", flags, 4'h0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i[1:0], rv);
      chk("rst_reg", rv, 8'h00);
    end

    // LDI/LDI/ADD/HALT
    imem[0] = ins(4'h7, 2'd0, 2'd0, 8'h05);
    imem[1] = ins(4'h7, 2'd1, 2'd0, 8'h03);
    imem[2] = ins(4'h0, 2'd0, 2'd1, 8'h00);
    imem[3] = ins(4'hF, 2'd0, 2'd0, 8'h00);
    push(4'h0, 8'h05, 8'h03);
    req_cnt = 0;
    pulse_start();
    run_halt(100, cyc);
    chk("t1_cycles", cyc, 13);
    rd_reg(2'd0, rv);
    chk("t1_r0", rv, 8'h08);
    chk("t1_flags", flags, 4'b0000);
    chk("t1_pc", pc, 8'h03);
    chk("t1_req_cnt", req_cnt, 4);
    chk("t1_sb_empty", sb.size(), 0);

    // Carry then BRC taken; restart from HALT keeps registers
    imem[0] = ins(4'h7, 2'd0, 2'd0, 8'hFF);
    imem[1] = ins(4'h7, 2'd1, 2'd0, 8'h01);
    imem[2] = ins(4'h0, 2'd0, 2'd1, 8'h00);
    imem[3] = ins(4'h9, 2'd0, 2'd0, 8'h10);
    push(4'h0, 8'hFF, 8'h01);
    pulse_start();
    chk("t2_restart_halted", halted, 0);
    chk("t2_restart_pc", pc, 8'h00);
    run_halt(100, cyc);
    rd_reg(2'd0, rv);
    chk("t2_r0", rv, 8'h00);
    chk("t2_flags", flags, 4'b1000);
    chk("t2_brc_pc", pc, 8'h10);

    // Same point with BRZ: not taken
    imem[3] = ins(4'h8, 2'd0, 2'd0, 8'h10);
    imem[4] = ins(4'hF, 2'd0, 2'd0, 8'h00);
    push(4'h0, 8'hFF, 8'h01);
    pulse_start();
    run_halt(100, cyc);
    chk("t2b_brz_pc", pc, 8'h04);
    chk("t2b_flags", flags, 4'b1000);

    // SUB rd==rs gives zero -> BRZ; SUB 3-9 negative -> BRN
    imem[0]    = ins(4'h7, 2'd2, 2'd0, 8'h07);
    imem[1]    = ins(4'h1, 2'd2, 2'd2, 8'h00);
    imem[2]    = ins(4'h8, 2'd0, 2'd0, 8'h20);
    imem[8'h20] = ins(4'h7, 2'd1, 2'd0, 8'h03);
    imem[8'h21] = ins(4'h7, 2'd3, 2'd0, 8'h09);
    imem[8'h22] = ins(4'h1, 2'd1, 2'd3, 8'h00);
    imem[8'h23] = ins(4'hA, 2'd0, 2'd0, 8'h30);
    push(4'h1, 8'h07, 8'h07);
    push(4'h1, 8'h03, 8'h09);
    pulse_start();
    run_halt(100, cyc);
    rd_reg(2'd2, rv);
    chk("t3_r2", rv, 8'h00);
    rd_reg(2'd1, rv);
    chk("t3_r1", rv, 8'hFA);
    chk("t3_flags", flags, 4'b0100);
    chk("t3_brn_pc", pc, 8'h30);

    // Back-to-back ADDs
    imem[0] = ins(4'h7, 2'd0, 2'd0, 8'h01);
    imem[1] = ins(4'h7, 2'd1, 2'd0, 8'h02);
    imem[2] = ins(4'h7, 2'd2, 2'd0, 8'h10);
    imem[3] = ins(4'h7, 2'd3, 2'd0, 8'h20);
    imem[4] = ins(4'h0, 2'd0, 2'd1, 8'h00);
    imem[5] = ins(4'h0, 2'd2, 2'd3, 8'h00);
    imem[6] = ins(4'hF, 2'd0, 2'd0, 8'h00);
    push(4'h0, 8'h01, 8'h02);
    push(4'h0, 8'h10, 8'h20);
    req_cnt = 0;
    pulse_start();
    run_halt(200, cyc);
    chk("t4_cycles", cyc, 23);
    rd_reg(2'd0, rv);
    chk("t4_r0", rv, 8'h03);
    rd_reg(2'd2, rv);
    chk("t4_r2", rv, 8'h30);
    chk("t4_flags", flags, 4'b0000);
    chk("t4_req_cnt", req_cnt, 7);
    chk("t4_sb_empty", sb.size(), 0);

    // Slow memory, JMP 0xFF then NOP wraps pc to 0
    lat     = 5;
    imem[0] = ins(4'h9, 2'd0, 2'd0, 8'h05);
    imem[1] = ins(4'h7, 2'd0, 2'd0, 8'hFF);
    imem[2] = ins(4'h7, 2'd1, 2'd0, 8'h01);
    imem[3] = ins(4'h0, 2'd0, 2'd1, 8'h00);
    imem[4] = ins(4'hB, 2'd0, 2'd0, 8'hFF);
    imem[5] = ins(4'hF, 2'd0, 2'd0, 8'h00);
    imem[8'hFF] = ins(4'hC, 2'd0, 2'd0, 8'h00);
    push(4'h0, 8'hFF, 8'h01);
    req_cnt  = 0;
    saw_wrap = 1'b0;
    pulse_start();
    run_halt(300, cyc);
    chk("t5_cycles", cyc, 57);
    chk("t5_req_cnt", req_cnt, 8);
    chk("t5_wrap", saw_wrap, 1);
    chk("t5_pc", pc, 8'h05);
    chk("t5_flags", flags, 4'b1000);

    // Async reset during EXEC of an ADD
    lat     = 1;
    imem[0] = ins(4'h0, 2'd0, 2'd1, 8'h00);
    push(4'h0, 8'h00, 8'h01);
    pulse_start();
    cyc = 0;
    while (alu_opcode !== 4'h0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reached_exec", alu_opcode, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_opcode", alu_opcode, 4'hF);
    chk("t6_async_a", alu_a, 8'h00);
    chk("t6_async_b", alu_b, 8'h00);
    chk("t6_async_pc", pc, 8'h00);
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_flags", flags, 4'h0);
    rd_reg(2'd1, rv);
    chk("t6_async_r1", rv, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd_reg(2'd0, rv);
    chk("t6_no_writeback_r0", rv, 8'h00);

    // Reset during WAIT; the late imem_valid must be ignored
    lat     = 5;
    imem[0] = ins(4'h7, 2'd2, 2'd0, 8'h55);
    imem[1] = ins(4'hF, 2'd0, 2'd0, 8'h00);
    req_cnt = 0;
    pulse_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t7_idle_req_cnt", req_cnt, 1);
    chk("t7_idle_pc", pc, 8'h00);
    chk("t7_idle_halted", halted, 0);
    rd_reg(2'd2, rv);
    chk("t7_late_valid_r2", rv, 8'h00);
    lat = 1;
    pulse_start();
    run_halt(100, cyc);
    rd_reg(2'd2, rv);
    chk("t7_resume_r2", rv, 8'h55);
    chk("t7_resume_pc", pc, 8'h01);
    chk("t7_req_cnt", req_cnt, 3);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the ALU operand/opcode interface: fetches 16-bit instructions, reads a 4x8 register file, drives opcode and operands to the combinational ALU, then captures result and flag back.
- Adds load-immediate, flag-conditional branches, jump and halt so the datapath runs small programs.
- Sits between instruction memory and the ALU. It is the control and register core of the microprocessor.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded at reset and on restart

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; leaves IDLE or HALT
imem_req  output  1  fetch request, one-cycle pulse
imem_addr  output  PC_W  fetch address, equals pc
imem_valid  input  1  instruction data valid, any cycle after req
imem_data  input  16  instruction word
alu_opcode  output  4  opcode to ALU
alu_a  output  8  operand A (reg[rd])
alu_b  output  8  operand B (reg[rs])
alu_out  input  8  ALU result
alu_flag  input  4  ALU flag: 1000 carry, 0100 negative, 0010 zero, 0000 none
pc  output  PC_W  current program counter
flags  output  4  latched flag register
halted  output  1  high in HALT
dbg_sel  input  2  register select for debug read
dbg_data  output  8  reg[dbg_sel], combinational

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, regs r0..r3=0, flags=0, imem_req=0, alu_opcode=4'b1111, alu_a=alu_b=0, halted=0.
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- ALU ops (0x0..0x6):
  - Encoding: add, sub, and, or, xor, shl, shr.
  - Semantics: rd <= rd op rs. Shifts use only alu_a.
- 0x7 LDI: rd <= imm.
- Branches: 0x8 BRZ if flags[1]; 0x9 BRC if flags[3]; 0xA BRN if flags[2]. Taken: pc <= imm[PC_W-1:0]; not taken: pc+1.
- 0xB JMP: pc <= imm.
- 0xF HALT.
- 0xC..0xE NOP: pc+1.
- FSM:
  - IDLE: wait for start, then go to FETCH.
  - FETCH: imem_req=1 for exactly one cycle, imem_addr=pc; next WAIT.
  - WAIT: hold until imem_valid=1; latch imem_data into ir; next EXEC.
  - EXEC, ALU op: drive alu_opcode=ir[15:12], alu_a=reg[rd], alu_b=reg[rs]; next WB.
  - EXEC, non-ALU op: resolve LDI/branch/JMP/NOP and update pc; next FETCH. HALT goes to HALT with pc unchanged.
  - WB: reg[rd] <= alu_out; flags <= alu_flag; pc <= pc+1; alu_opcode returns to 4'b1111; next FETCH.
  - HALT: halted=1; start sets pc=RESET_PC, halted=0, next FETCH; registers and flags retained.
- alu_opcode is parked at 4'b1111 (undecoded by the ALU) in every state except EXEC/WB. Every ALU instruction therefore produces an opcode change, so back-to-back identical opcodes re-evaluate.
- Flags are updated only by ALU ops. LDI, branch and NOP preserve flags.
- Latency, with imem_valid one cycle after req: ALU op = 4 cycles (FETCH, WAIT, EXEC, WB); non-ALU op = 3 cycles.
- pc+1 wraps 2^PC_W-1 -> 0. Branch target is truncated to PC_W bits.
- Ignored inputs:
  - imem_valid outside WAIT is ignored.
  - start outside IDLE/HALT is ignored.
  - A start pulse coincident with reset deassertion is ignored.
- rd==rs is legal; both operands are read before write-back.
- Reset during WAIT abandons the fetch; a late imem_valid after reset is ignored.

Test Plan:
- Reset then start, imem returns LDI r0,0x05 / LDI r1,0x03 / ADD r0,r1 / HALT -> r0=0x08, flags=0000, halted=1, pc=3. ADD drives alu_opcode=0000, a=0x05, b=0x03.
- LDI r0,0xFF; LDI r1,0x01; ADD r0,r1; BRC 0x10 -> r0=0x00, flags=1000, pc=0x10 after the branch. BRZ at the same point not taken -> pc=4.
- LDI r2,0x07; SUB r2,r2; BRZ 0x20 -> r2=0, flags=0010, branch taken. SUB with r2=3, r3=9 -> flags=0100, BRN taken.
- Two consecutive ADDs with different operands -> alu_opcode shows 1111 between them; both write-backs correct.
- imem_valid delayed 5 cycles -> FSM holds WAIT, imem_req a single pulse. JMP 0xFF followed by NOP at 0xFF -> pc wraps to 0x00.
- Assert rst during EXEC of an ADD -> all outputs at reset values immediately (asynchronous), no write-back. A late imem_valid is ignored; start resumes from RESET_PC.
